// File: rtl/rslatch_driver.sv
// Clocked write controller for an external RS latch: pulses s/r/en, then verifies q/nq through a synchronizer.
// Optional RSLATCH_DRV_SKIP_EN: requests already matching the synchronized readback complete without driving.
module rslatch_driver #(
   parameter int PULSE_W     = 4,
   parameter int TIMEOUT     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_val,
   output logic s,
   output logic r,
   output logic en,
   input  logic q_in,
   input  logic nq_in,
   output logic done,
   output logic err,
   output logic q_sync
);

   localparam int CMAX = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam logic [CW-1:0] C_PULSE  = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] C_TMO    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_SETTLE = CW'(SYNC_STAGES - 1);
   localparam logic [CW-1:0] C_SAT    = {CW{1'b1}};

   typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

   state_t                 r_state, w_nstate;
   logic [CW-1:0]          r_cnt, w_cnt_nxt, w_cnt_inc;
   logic                   r_tgt, w_tgt_nxt;
   logic [SYNC_STAGES-1:0] r_qs, r_nqs;
   logic                   w_qs, w_nqs, w_match, w_settled, w_tmo;
   logic                   w_s_nxt, w_r_nxt, w_en_nxt, w_done_nxt, w_err_nxt, w_ready_nxt;

   assign w_qs      = r_qs[SYNC_STAGES-1];
   assign w_nqs     = r_nqs[SYNC_STAGES-1];
   assign q_sync    = w_qs;
   assign w_match   = (w_qs == r_tgt) && (w_nqs == ~r_tgt);
   assign w_cnt_inc = (r_cnt == C_SAT) ? r_cnt : r_cnt + CW'(1);
   assign w_tmo     = (r_cnt == C_TMO);
   // Early WAIT samples may still carry values captured while the pulse was active.
   assign w_settled = (r_cnt >= C_SETTLE);

   always_comb begin
      w_nstate   = r_state;
      w_cnt_nxt  = r_cnt;
      w_tgt_nxt  = r_tgt;
      w_s_nxt    = 1'b0;
      w_r_nxt    = 1'b0;
      w_en_nxt   = 1'b0;
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid && req_ready) begin
`ifdef RSLATCH_DRV_SKIP_EN
               if ((w_qs == req_val) && (w_nqs == ~req_val)) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_tgt_nxt = req_val;
                  w_cnt_nxt = '0;
                  w_nstate  = DRIVE;
                  w_s_nxt   = req_val;
                  w_r_nxt   = ~req_val;
                  w_en_nxt  = 1'b1;
               end
`else
               w_tgt_nxt = req_val;
               w_cnt_nxt = '0;
               w_nstate  = DRIVE;
               w_s_nxt   = req_val;
               w_r_nxt   = ~req_val;
               w_en_nxt  = 1'b1;
`endif
            end
         end
         DRIVE: begin
            if (r_cnt == C_PULSE) begin
               w_cnt_nxt = '0;
               w_nstate  = WAIT;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               w_s_nxt   = r_tgt;
               w_r_nxt   = ~r_tgt;
               w_en_nxt  = 1'b1;
            end
         end
         WAIT: begin
            // A match on the timeout cycle still counts as success.
            if (w_match && (w_settled || w_tmo)) begin
               w_done_nxt = 1'b1;
               w_cnt_nxt  = '0;
               w_nstate   = IDLE;
            end else if (w_tmo) begin
               w_err_nxt  = 1'b1;
               w_cnt_nxt  = '0;
               w_nstate   = IDLE;
            end else begin
               w_cnt_nxt  = w_cnt_inc;
            end
         end
         default: begin
            w_cnt_nxt = '0;
            w_nstate  = IDLE;
         end
      endcase
      w_ready_nxt = (w_nstate == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_tgt     <= 1'b0;
         r_qs      <= '0;
         r_nqs     <= '0;
         s         <= 1'b0;
         r         <= 1'b0;
         en        <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         req_ready <= 1'b0;
      end else begin
         r_state   <= w_nstate;
         r_cnt     <= w_cnt_nxt;
         r_tgt     <= w_tgt_nxt;
         r_qs      <= {r_qs[SYNC_STAGES-2:0], q_in};
         r_nqs     <= {r_nqs[SYNC_STAGES-2:0], nq_in};
         s         <= w_s_nxt;
         r         <= w_r_nxt;
         en        <= w_en_nxt;
         done      <= w_done_nxt;
         err       <= w_err_nxt;
         req_ready <= w_ready_nxt;
      end
   end

endmodule
